// File: rtl/hovalaag_bus_pkg.sv
// Shared definitions for the Hovalaag wrapper bus: addresses, status bits,
// host-driver FSM states and the request payload with its 6-bit chunk map.
package hovalaag_bus_pkg;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DIN_W      = 6;
  localparam int unsigned DOUT_W     = 8;
  localparam int unsigned NUM_CHUNKS = 9;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned VAL_W      = 12;
  localparam int unsigned STAT_W     = 4;
  localparam int unsigned PC_W       = 8;

  localparam logic [ADDR_W-1:0] ADDR_INSTR0    = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_INSTR1    = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_INSTR2    = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_INSTR3    = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_INSTR4    = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_EXEC      = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_IN1_LO    = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_IN1_HI    = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_IN2_LO    = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_IN2_HI    = 4'd9;
  localparam logic [ADDR_W-1:0] ADDR_RD_PC     = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_RD_OUT_LO = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_RD_OUT_HI = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_IDLE      = 4'd15;

  localparam int unsigned STAT_IN1_ADV    = 0;
  localparam int unsigned STAT_IN2_ADV    = 1;
  localparam int unsigned STAT_OUT1_VALID = 2;
  localparam int unsigned STAT_OUT2_VALID = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    EXEC,
    RD_PC,
    RD_OUTL,
    RD_OUTH,
    RESP
  } state_t;

  typedef logic [DIN_W-1:0] chunk_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [VAL_W-1:0]   in1;
    logic [VAL_W-1:0]   in2;
  } req_t;

  // Wrapper address of chunk idx, in write order.
  function automatic logic [ADDR_W-1:0] chunk_addr(input int unsigned idx);
    case (idx)
      0:       chunk_addr = ADDR_IN1_LO;
      1:       chunk_addr = ADDR_IN1_HI;
      2:       chunk_addr = ADDR_IN2_LO;
      3:       chunk_addr = ADDR_IN2_HI;
      4:       chunk_addr = ADDR_INSTR0;
      5:       chunk_addr = ADDR_INSTR1;
      6:       chunk_addr = ADDR_INSTR2;
      7:       chunk_addr = ADDR_INSTR3;
      8:       chunk_addr = ADDR_INSTR4;
      default: chunk_addr = ADDR_IDLE;
    endcase
  endfunction

  // Payload bits carried by chunk idx.
  function automatic chunk_t chunk_data(input req_t r, input int unsigned idx);
    case (idx)
      0:       chunk_data = r.in1[5:0];
      1:       chunk_data = r.in1[11:6];
      2:       chunk_data = r.in2[5:0];
      3:       chunk_data = r.in2[11:6];
      4:       chunk_data = r.instr[5:0];
      5:       chunk_data = r.instr[11:6];
      6:       chunk_data = r.instr[17:12];
      7:       chunk_data = r.instr[23:18];
      8:       chunk_data = r.instr[29:24];
      default: chunk_data = '0;
    endcase
  endfunction

endpackage

// File: rtl/hovalaag_chunk_sched.sv
// Picks the lowest-order dirty chunk as a one-hot vector.
module hovalaag_chunk_sched
  import hovalaag_bus_pkg::*;
(
  input  logic [NUM_CHUNKS-1:0] dirty,
  output logic [NUM_CHUNKS-1:0] pick,
  output logic                  any
);

  // x & -x isolates the lowest set bit.
  assign pick = dirty & (~dirty + NUM_CHUNKS'(1));
  assign any  = |dirty;

endmodule

// File: rtl/hovalaag_host_driver.sv
// Host-side initiator that serialises one execute request into Hovalaag
// wrapper bus cycles and collects status, PC and OUT into one response.
module hovalaag_host_driver
  import hovalaag_bus_pkg::*;
#(
  parameter bit SKIP_UNCHANGED = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [11:0] req_in1,
  input  logic [11:0] req_in2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [3:0]  resp_status,
  output logic [7:0]  resp_pc,
  output logic [11:0] resp_out,
  output logic        hov_reset,
  output logic [3:0]  hov_addr,
  output logic [5:0]  hov_io_in,
  input  logic [7:0]  hov_io_out,
  output logic        busy
);

  state_t                  state_q, state_d;
  req_t                    req_q, req_d, req_in, src;
  logic [NUM_CHUNKS-1:0]   dirty_q, dirty_d, dirty_new, sched_in, pick;
  logic                    any;
  chunk_t                  shadow_q [NUM_CHUNKS];
  chunk_t                  shadow_d [NUM_CHUNKS];
  logic [ADDR_W-1:0]       pick_addr, addr_d;
  chunk_t                  pick_data, io_in_d;
  logic                    resp_valid_d, launch;
  logic [STAT_W-1:0]       status_d;
  logic [PC_W-1:0]         pc_d;
  logic [VAL_W-1:0]        out_d;

  assign req_in = '{instr: req_instr, in1: req_in1, in2: req_in2};

  // Chunk payloads come straight from the request port on the accept cycle.
  always_comb begin
    src = (state_q == IDLE) ? req_in : req_q;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      dirty_new[i] = !SKIP_UNCHANGED || (chunk_data(req_in, i) != shadow_q[i]);
    end
    sched_in = (state_q == IDLE) ? dirty_new : dirty_q;
  end

  hovalaag_chunk_sched u_sched (
    .dirty (sched_in),
    .pick  (pick),
    .any   (any)
  );

  always_comb begin
    pick_addr = ADDR_IDLE;
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (pick[i]) begin
        pick_addr = chunk_addr(i);
        pick_data = chunk_data(src, i);
      end
    end
  end

  // Next-state and next-output logic; all bus and response outputs are registered.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    dirty_d      = dirty_q;
    shadow_d     = shadow_q;
    addr_d       = hov_addr;
    io_in_d      = hov_io_in;
    resp_valid_d = resp_valid;
    status_d     = resp_status;
    pc_d         = resp_pc;
    out_d        = resp_out;
    launch       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d  = req_in;
          launch = 1'b1;
        end
      end
      WRITE: launch = 1'b1;
      EXEC: begin
        status_d = hov_io_out[STAT_W-1:0];
        state_d  = RD_PC;
        addr_d   = ADDR_RD_PC;
        // Read addresses alias write registers; replay the shadow so a write is harmless.
        io_in_d  = shadow_q[0];
      end
      RD_PC: begin
        pc_d = hov_io_out;
        if (resp_status[STAT_OUT2_VALID] || resp_status[STAT_OUT1_VALID]) begin
          state_d = RD_OUTL;
          addr_d  = ADDR_RD_OUT_LO;
          io_in_d = shadow_q[1];
        end else begin
          out_d        = '0;
          state_d      = RESP;
          addr_d       = ADDR_IDLE;
          io_in_d      = '0;
          resp_valid_d = 1'b1;
        end
      end
      RD_OUTL: begin
        out_d[7:0] = hov_io_out;
        state_d    = RD_OUTH;
        addr_d     = ADDR_RD_OUT_HI;
        io_in_d    = shadow_q[2];
      end
      RD_OUTH: begin
        out_d[11:8]  = hov_io_out[3:0];
        state_d      = RESP;
        addr_d       = ADDR_IDLE;
        io_in_d      = '0;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Drive the next dirty chunk, or the execute cycle once none remain.
    if (launch) begin
      if (any) begin
        state_d = WRITE;
        addr_d  = pick_addr;
        io_in_d = pick_data;
        dirty_d = sched_in & ~pick;
        for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
          if (pick[i]) shadow_d[i] = pick_data;
        end
      end else begin
        state_d = EXEC;
        addr_d  = ADDR_EXEC;
        io_in_d = {4'b0000, src.instr[31:30]};
        dirty_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    hov_reset <= !reset_n;
    if (!reset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      dirty_q     <= '0;
      for (int unsigned i = 0; i < NUM_CHUNKS; i++) shadow_q[i] <= '0;
      hov_addr    <= ADDR_IDLE;
      hov_io_in   <= '0;
      resp_valid  <= 1'b0;
      resp_status <= '0;
      resp_pc     <= '0;
      resp_out    <= '0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      dirty_q     <= dirty_d;
      shadow_q    <= shadow_d;
      hov_addr    <= addr_d;
      hov_io_in   <= io_in_d;
      resp_valid  <= resp_valid_d;
      resp_status <= status_d;
      resp_pc     <= pc_d;
      resp_out    <= out_d;
      req_ready   <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_hovalaag_host_driver.sv
// Directed bench for hovalaag_host_driver with a small wrapper read model.
module tb_hovalaag_host_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_instr;
  logic [11:0] req_in1;
  logic [11:0] req_in2;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_status;
  logic [7:0]  resp_pc;
  logic [11:0] resp_out;
  logic        hov_reset;
  logic [3:0]  hov_addr;
  logic [5:0]  hov_io_in;
  logic [7:0]  hov_io_out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [3:0] m_status;
  logic [7:0] m_pc, m_outl, m_outh;

  logic [3:0] la[$];
  logic [5:0] ld[$];
  logic [3:0] ea[$];
  logic [5:0] ed[$];

  hovalaag_host_driver #(.SKIP_UNCHANGED(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_instr   (req_instr),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_status (resp_status),
    .resp_pc     (resp_pc),
    .resp_out    (resp_out),
    .hov_reset   (hov_reset),
    .hov_addr    (hov_addr),
    .hov_io_in   (hov_io_in),
    .hov_io_out  (hov_io_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper read side: status at EXEC, PC and OUT at the read addresses.
  always_comb begin
    case (hov_addr)
      4'd5:    hov_io_out = {4'b0000, m_status};
      4'd6:    hov_io_out = m_pc;
      4'd7:    hov_io_out = m_outl;
      4'd8:    hov_io_out = m_outh;
      default: hov_io_out = 8'h00;
    endcase
  end

  // Bus log of every non-idle cycle.
  always @(posedge clk) begin
    #1;
    if (hov_addr != 4'd15) begin
      la.push_back(hov_addr);
      ld.push_back(hov_io_in);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_log(input string tag, input int ndata);
    check({tag, "_len"}, 32'(la.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < la.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(la[i]), 32'(ea[i]));
      if (i < ndata) check($sformatf("%s_data%0d", tag, i), 32'(ld[i]), 32'(ed[i]));
    end
  endtask

  task automatic do_req(input string tag, input logic [31:0] instr, input logic [11:0] in1,
                        input logic [11:0] in2, input int hold, input int exp_lat,
                        input logic [3:0] exp_st, input logic [7:0] exp_pc,
                        input logic [11:0] exp_out);
    int n;
    int acc;
    la.delete();
    ld.delete();
    req_instr  = instr;
    req_in1    = in1;
    req_in2    = in2;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!resp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    check({tag, "_lat"}, 32'(cyc - acc), 32'(exp_lat));
    check({tag, "_status"}, 32'(resp_status), 32'(exp_st));
    check({tag, "_pc"}, 32'(resp_pc), 32'(exp_pc));
    check({tag, "_out"}, 32'(resp_out), 32'(exp_out));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d_valid", tag, h), 32'(resp_valid), 32'd1);
      check($sformatf("%s_hold%0d_fields", tag, h), {8'h00, resp_out, resp_pc, resp_status},
            {8'h00, exp_out, exp_pc, exp_st});
      check($sformatf("%s_hold%0d_ready", tag, h), 32'(req_ready), 32'd0);
      check($sformatf("%s_hold%0d_addr", tag, h), 32'(hov_addr), 32'd15);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_instr  = '0;
    req_in1    = '0;
    req_in2    = '0;
    resp_ready = 1'b1;
    m_status   = 4'h0;
    m_pc       = 8'h00;
    m_outl     = 8'h00;
    m_outh     = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_hov_reset", 32'(hov_reset), 32'd1);
    check("rst_addr", 32'(hov_addr), 32'd15);
    check("rst_io_in", 32'(hov_io_in), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp", {11'd0, resp_valid, resp_out, resp_pc}, 32'd0);
    check("rst_status_busy", {27'd0, busy, resp_status}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_hov_reset_hi", 32'(hov_reset), 32'd1);
    @(negedge clk);
    check("rel_hov_reset_lo", 32'(hov_reset), 32'd0);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // All-zero request after reset: nothing to write.
    m_pc = 8'h01;
    ea = '{4'd5, 4'd6};
    ed = '{6'h00};
    do_req("zero", 32'h0000_0000, 12'h000, 12'h000, 0, 2, 4'h0, 8'h01, 12'h000);
    expect_log("zero_log", 1);

    // Fresh values: chunks still equal to zero shadows are skipped.
    m_pc = 8'h02;
    ea = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd5, 4'd6};
    ed = '{6'h3F, 6'h3F, 6'h01, 6'h01, 6'h3C, 6'h2A, 6'h04, 6'h03};
    do_req("full", 32'hC000_4ABC, 12'hFFF, 12'h041, 0, 9, 4'h0, 8'h02, 12'h000);
    expect_log("full_log", 8);

    // Identical request with OUT readback and response back-pressure.
    m_status = 4'h4;
    m_pc     = 8'h03;
    m_outl   = 8'h5A;
    m_outh   = 8'h03;
    ea = '{4'd5, 4'd6, 4'd7, 4'd8};
    ed = '{6'h03};
    do_req("repeat", 32'hC000_4ABC, 12'hFFF, 12'h041, 5, 4, 4'h4, 8'h03, 12'h35A);
    expect_log("repeat_log", 1);

    // Every chunk changes and both OUT reads happen: longest request.
    m_status = 4'hC;
    m_pc     = 8'h80;
    m_outl   = 8'hA5;
    m_outh   = 8'hF7;
    ea = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    ed = '{6'h15, 6'h15, 6'h2A, 6'h2A, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h00};
    do_req("max", 32'h3FFF_FFFF, 12'h555, 12'hAAA, 0, 13, 4'hC, 8'h80, 12'h7A5);
    expect_log("max_log", 10);

    // Reset while the third chunk is on the bus.
    req_instr = 32'h1234_5678;
    req_in1   = 12'h123;
    req_in2   = 12'h456;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_third_chunk", 32'(hov_addr), 32'd8);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_addr", 32'(hov_addr), 32'd15);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_hov_reset", 32'(hov_reset), 32'd1);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rel_hov_reset", 32'(hov_reset), 32'd0);
    repeat (3) @(negedge clk);
    check("mid_no_resp", 32'(resp_valid), 32'd0);

    // Shadows are back to zero, so every nonzero chunk is rewritten.
    m_status = 4'h1;
    m_pc     = 8'h44;
    ea = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    ed = '{6'h23, 6'h04, 6'h16, 6'h11, 6'h38, 6'h19, 6'h05, 6'h0D, 6'h12, 6'h00};
    do_req("after_rst", 32'h1234_5678, 12'h123, 12'h456, 0, 11, 4'h1, 8'h44, 12'h000);
    expect_log("after_rst_log", 10);

    // Only IN1 low chunk differs.
    m_status = 4'h0;
    m_pc     = 8'h45;
    ea = '{4'd6, 4'd5, 4'd6};
    ed = '{6'h24, 6'h00};
    do_req("one", 32'h1234_5678, 12'h124, 12'h456, 0, 3, 4'h0, 8'h45, 12'h000);
    expect_log("one_log", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
